// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on hazards
// or MEM-stage redirects, PC/IF-ID stall generation and saturating stall/flush counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [10:0]      id_ex_sig,
  input  logic [4:0]       id_mem_sig,
  input  logic [4:0]       id_wb_sig,
  input  logic             id_memread,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [10:0]      ex_ex_sig,
  output logic [4:0]       ex_mem_sig,
  output logic [4:0]       ex_wb_sig,
  output logic             ex_memread,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             hz_s;
  logic             bubble_s;
  logic             stall_s;
  logic             ex_valid_r;
  logic [XLEN-1:0]  ex_pc_r;
  logic [XLEN-1:0]  ex_rs1_data_r;
  logic [XLEN-1:0]  ex_rs2_data_r;
  logic [XLEN-1:0]  ex_imm_r;
  logic [4:0]       ex_rs1_r;
  logic [4:0]       ex_rs2_r;
  logic [4:0]       ex_rd_r;
  logic [2:0]       ex_funct3_r;
  logic [10:0]      ex_ex_sig_r;
  logic [4:0]       ex_mem_sig_r;
  logic [4:0]       ex_wb_sig_r;
  logic             ex_memread_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Load-use hazard, bubble and stall decisions; rs2 is compared for every format.
  always_comb begin
    hz_s     = 1'b0;
    bubble_s = 1'b0;
    stall_s  = 1'b0;
    if (ex_valid_r && ex_memread_r && (ex_rd_r != 5'd0) && id_valid &&
        ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2))) begin
      hz_s = 1'b1;
    end else begin
      hz_s = 1'b0;
    end
    bubble_s = flush | hz_s | ~id_valid;
    stall_s  = hz_s & ~flush;
  end

  assign pc_write   = ~stall_s;
  assign ifid_write = ~stall_s;

  // Pipeline register: control bundles are zeroed on a bubble, data fields always follow ID.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_r    <= 1'b0;
      ex_pc_r       <= {XLEN{1'b0}};
      ex_rs1_data_r <= {XLEN{1'b0}};
      ex_rs2_data_r <= {XLEN{1'b0}};
      ex_imm_r      <= {XLEN{1'b0}};
      ex_rs1_r      <= 5'd0;
      ex_rs2_r      <= 5'd0;
      ex_rd_r       <= 5'd0;
      ex_funct3_r   <= 3'd0;
      ex_ex_sig_r   <= 11'd0;
      ex_mem_sig_r  <= 5'd0;
      ex_wb_sig_r   <= 5'd0;
      ex_memread_r  <= 1'b0;
    end else begin
      ex_pc_r       <= id_pc;
      ex_rs1_data_r <= id_rs1_data;
      ex_rs2_data_r <= id_rs2_data;
      ex_imm_r      <= id_imm;
      ex_rs1_r      <= id_rs1;
      ex_rs2_r      <= id_rs2;
      ex_rd_r       <= id_rd;
      ex_funct3_r   <= id_funct3;
      if (bubble_s) begin
        ex_valid_r   <= 1'b0;
        ex_ex_sig_r  <= 11'd0;
        ex_mem_sig_r <= 5'd0;
        ex_wb_sig_r  <= 5'd0;
        ex_memread_r <= 1'b0;
      end else begin
        ex_valid_r   <= 1'b1;
        ex_ex_sig_r  <= id_ex_sig;
        ex_mem_sig_r <= id_mem_sig;
        ex_wb_sig_r  <= id_wb_sig;
        ex_memread_r <= id_memread;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign ex_valid    = ex_valid_r;
  assign ex_pc       = ex_pc_r;
  assign ex_rs1_data = ex_rs1_data_r;
  assign ex_rs2_data = ex_rs2_data_r;
  assign ex_imm      = ex_imm_r;
  assign ex_rs1      = ex_rs1_r;
  assign ex_rs2      = ex_rs2_r;
  assign ex_rd       = ex_rd_r;
  assign ex_funct3   = ex_funct3_r;
  assign ex_ex_sig   = ex_ex_sig_r;
  assign ex_mem_sig  = ex_mem_sig_r;
  assign ex_wb_sig   = ex_wb_sig_r;
  assign ex_memread  = ex_memread_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural model of the
// instruction held in EX and the stall/flush event counts (counters narrowed to 4 bits).
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk, rstn;
  logic             id_valid, id_memread, flush;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [2:0]       id_funct3;
  logic [10:0]      id_ex_sig;
  logic [4:0]       id_mem_sig, id_wb_sig;
  logic             ex_valid, ex_memread, pc_write, ifid_write;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_funct3;
  logic [10:0]      ex_ex_sig;
  logic [4:0]       ex_mem_sig, ex_wb_sig;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_ex_sig(id_ex_sig), .id_mem_sig(id_mem_sig), .id_wb_sig(id_wb_sig),
    .id_memread(id_memread), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_ex_sig(ex_ex_sig), .ex_mem_sig(ex_mem_sig), .ex_wb_sig(ex_wb_sig),
    .ex_memread(ex_memread), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what EX should hold: the last accepted instruction, or an empty slot.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [10:0] exs;
    logic [4:0]  mems, wbs;
    logic        memread;
  } ex_t;

  ex_t m;
  int  m_stall, m_flush;
  int  checks, errors;

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m = '{valid: 1'b0, pc: 32'd0, rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0, rs1: 5'd0,
          rs2: 5'd0, rd: 5'd0, f3: 3'd0, exs: 11'd0, mems: 5'd0, wbs: 5'd0, memread: 1'b0};
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check_regs();
    check_val("ex_valid", {159'd0, ex_valid}, {159'd0, m.valid});
    check_val("ctrl", {138'd0, ex_ex_sig, ex_mem_sig, ex_wb_sig, ex_memread},
              {138'd0, m.exs, m.mems, m.wbs, m.memread});
    check_val("data", {14'd0, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3},
              {14'd0, m.pc, m.rs1d, m.rs2d, m.imm, m.rs1, m.rs2, m.rd, m.f3});
    check_val("stall_cnt", {156'd0, stall_cnt}, 160'(m_stall));
    check_val("flush_cnt", {156'd0, flush_cnt}, 160'(m_flush));
  endtask

  function automatic logic model_hazard();
    return m.valid && m.memread && (m.rd != 5'd0) && id_valid &&
           ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  // One clock: check stall outputs, clock, advance the model, check EX.
  task automatic step(output logic stalled);
    logic hz, st;
    ex_t  nx;
    #3;
    hz = model_hazard();
    st = hz && !flush;
    check_val("pc_write", {159'd0, pc_write}, {159'd0, !st});
    check_val("ifid_write", {159'd0, ifid_write}, {159'd0, !st});
    nx = '{valid: 1'b1, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data, imm: id_imm,
           rs1: id_rs1, rs2: id_rs2, rd: id_rd, f3: id_funct3, exs: id_ex_sig,
           mems: id_mem_sig, wbs: id_wb_sig, memread: id_memread};
    if (flush || hz || !id_valid) begin
      nx.valid = 1'b0; nx.exs = 11'd0; nx.mems = 5'd0; nx.wbs = 5'd0; nx.memread = 1'b0;
    end
    @(posedge clk);
    m = nx;
    if (st && m_stall < CMAX) m_stall++;
    if (flush && m_flush < CMAX) m_flush++;
    #1;
    check_regs();
    stalled = st;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic fl,
                       input logic [10:0] exs, input logic [4:0] wbs);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_memread = mr; flush = fl;
    id_ex_sig = exs; id_wb_sig = wbs; id_mem_sig = 5'($urandom_range(0, 31));
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom; id_funct3 = 3'($urandom_range(0, 7));
  endtask

  // Present an instruction and hold it while IF/ID is stalled; a stall must last one cycle.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic fl,
                       input logic [10:0] exs, input logic [4:0] wbs);
    logic st;
    drive(v, rs1, rs2, rd, mr, fl, exs, wbs);
    step(st);
    if (st) begin
      flush = 1'b0;
      step(st);
      check_val("stall_len", {159'd0, st}, 160'd0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    model_clear();
    rstn = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'd0, 5'd0);
    #2;
    check_regs();
    check_val("pc_write_rst", {159'd0, pc_write}, 160'd1);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // load then an immediate ALU op: passthrough and load in EX one edge later
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 11'h401, 5'h11);
    check_val("lw_memread", {159'd0, ex_memread}, 160'd1);
    // load-use on rs1: one bubble, then the add
    issue(1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 11'h002, 5'h10);
    check_val("stall_one", {156'd0, stall_cnt}, 160'd1);
    // independent add after load, and a load to x0 followed by reads of x0
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 11'h401, 5'h11);
    issue(1'b1, 5'd7, 5'd8, 5'd6, 1'b0, 1'b0, 11'h002, 5'h10);
    issue(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 11'h401, 5'h11);
    issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 11'h002, 5'h10);
    check_val("no_stall", {156'd0, stall_cnt}, 160'd1);
    // flush coincident with a hazard: no stall, bubble
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 11'h401, 5'h11);
    issue(1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1, 11'h002, 5'h10);
    check_val("flush_bubble", {159'd0, ex_valid}, 160'd0);

    // reset while a stall is pending
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 11'h401, 5'h11);
    drive(1'b1, 5'd2, 5'd5, 5'd6, 1'b0, 1'b0, 11'h002, 5'h10);
    #2;
    check_val("pre_rst_stall", {159'd0, pc_write}, 160'd0);
    rstn = 1'b0;
    #1;
    model_clear();
    check_regs();
    check_val("rst_pc_write", {159'd0, pc_write}, 160'd1);
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 5'd2, 5'd5, 5'd6, 1'b0, 1'b0, 11'h002, 5'h10);

    // repeated load-use pairs drive the stall counter into saturation
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 11'h401, 5'h11);
      issue(1'b1, 5'd3, 5'd9, 5'd4, 1'b0, 1'b0, 11'h002, 5'h10);
    end
    check_val("stall_sat", {156'd0, stall_cnt}, 160'd15);

    // random traffic over a small register set for frequent hazards
    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            11'($urandom), 5'($urandom));
    end
    check_val("flush_sat", {156'd0, flush_cnt}, 160'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
